// File: rtl/td4_op_decoder_if.sv
// Opcode/carry inputs and mux-select/load-enable outputs of the TD4 decoder.
interface td4_op_decoder_if;
    logic [3:0] in_op;
    logic       in_alu_c;
    logic       out_s0;
    logic       out_s1;
    logic       out_r0;
    logic       out_r1;
    logic       out_r2;
    logic       out_r3;

    modport master (
        output in_op, in_alu_c,
        input  out_s0, out_s1, out_r0, out_r1, out_r2, out_r3
    );

    modport slave (
        input  in_op, in_alu_c,
        output out_s0, out_s1, out_r0, out_r1, out_r2, out_r3
    );
endinterface

// File: rtl/td4_op_decoder.sv
// TD4 instruction decoder: combinational opcode decode into mux select and
// one-hot register loads, plus the carry flag consulted by JNC.
module td4_op_decoder (
    input logic              clk,
    input logic              rst_n,
    td4_op_decoder_if.slave  bus
);

    logic       carry_q;
    logic       carry_d;
    logic [1:0] sel;
    logic [3:0] load;   // {PC, OUT, B, A}

    always_comb begin
        carry_d = bus.in_alu_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    // Anything that does not match a defined opcode (including X/Z) decodes as NOP.
    always_comb begin
        sel  = 2'b11;
        load = 4'b0000;
        if (rst_n) begin
            case (bus.in_op)
                4'b0000: begin sel = 2'b00; load = 4'b0001; end
                4'b0001: begin sel = 2'b01; load = 4'b0001; end
                4'b0010: begin sel = 2'b10; load = 4'b0001; end
                4'b0011: begin sel = 2'b11; load = 4'b0001; end
                4'b0100: begin sel = 2'b00; load = 4'b0010; end
                4'b0101: begin sel = 2'b01; load = 4'b0010; end
                4'b0110: begin sel = 2'b10; load = 4'b0010; end
                4'b0111: begin sel = 2'b11; load = 4'b0010; end
                4'b1001: begin sel = 2'b01; load = 4'b0100; end
                4'b1011: begin sel = 2'b11; load = 4'b0100; end
                4'b1110: begin sel = 2'b11; load = {~carry_q, 3'b000}; end
                4'b1111: begin sel = 2'b11; load = 4'b1000; end
                default: begin sel = 2'b11; load = 4'b0000; end
            endcase
        end
    end

    assign bus.out_s1 = sel[1];
    assign bus.out_s0 = sel[0];
    assign bus.out_r0 = load[0];
    assign bus.out_r1 = load[1];
    assign bus.out_r2 = load[2];
    assign bus.out_r3 = load[3];

endmodule

// File: tb/tb_td4_op_decoder.sv
// Directed-vector bench for td4_op_decoder with a hand-written decode table.
module tb_td4_op_decoder;

    logic clk;
    logic rst_n;

    td4_op_decoder_if bus ();

    td4_op_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Expected outputs packed as {s1, s0, r3, r2, r1, r0}, carry flag = 0.
    logic [5:0] exp_tab [16];

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] obs();
        return {bus.out_s1, bus.out_s0, bus.out_r3, bus.out_r2, bus.out_r1, bus.out_r0};
    endfunction

    function automatic logic [5:0] onehot_ok();
        int cnt;
        cnt = int'(bus.out_r0) + int'(bus.out_r1) + int'(bus.out_r2) + int'(bus.out_r3);
        return (cnt <= 1) ? 6'd1 : 6'd0;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_tab[0]  = 6'b00_0001;
        exp_tab[1]  = 6'b01_0001;
        exp_tab[2]  = 6'b10_0001;
        exp_tab[3]  = 6'b11_0001;
        exp_tab[4]  = 6'b00_0010;
        exp_tab[5]  = 6'b01_0010;
        exp_tab[6]  = 6'b10_0010;
        exp_tab[7]  = 6'b11_0010;
        exp_tab[8]  = 6'b11_0000;
        exp_tab[9]  = 6'b01_0100;
        exp_tab[10] = 6'b11_0000;
        exp_tab[11] = 6'b11_0100;
        exp_tab[12] = 6'b11_0000;
        exp_tab[13] = 6'b11_0000;
        exp_tab[14] = 6'b11_1000;
        exp_tab[15] = 6'b11_1000;

        rst_n        = 1'b0;
        bus.in_op    = 4'b0000;
        bus.in_alu_c = 1'b0;

        // Reset held: every opcode is NOP.
        for (int i = 0; i < 16; i++) begin
            bus.in_op = 4'(i);
            #1;
            check_eq($sformatf("rst_op%0d", i), obs(), 6'b11_0000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Flag = 0 sweep, wrapping 1111 -> 0000.
        for (int i = 0; i < 17; i++) begin
            bus.in_op = 4'(i % 16);
            #1;
            check_eq($sformatf("dec_op%0d", i % 16), obs(), exp_tab[i % 16]);
            check_eq($sformatf("onehot_op%0d", i % 16), onehot_ok(), 6'd1);
        end

        // Carry set: JNC must not load.
        bus.in_alu_c = 1'b1;
        @(posedge clk);
        #1;
        bus.in_op = 4'b1110;
        #1;
        check_eq("jnc_c1", obs(), 6'b11_0000);

        // Flag = 1: JMP still loads PC; other opcodes unaffected.
        bus.in_op = 4'b1111;
        #1;
        check_eq("jmp_c1", obs(), 6'b11_1000);
        bus.in_op = 4'b0101;
        #1;
        check_eq("addb_c1", obs(), 6'b01_0010);

        // Carry clear: JNC loads again.
        bus.in_alu_c = 1'b0;
        @(posedge clk);
        #1;
        bus.in_op = 4'b1110;
        #1;
        check_eq("jnc_c0", obs(), 6'b11_1000);

        // Set the flag, then reset asynchronously mid-cycle.
        bus.in_alu_c = 1'b1;
        @(posedge clk);
        #1;
        check_eq("jnc_pre_rst", obs(), 6'b11_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("jnc_in_rst", obs(), 6'b11_0000);
        bus.in_op = 4'b0000;
        #1;
        check_eq("add_in_rst", obs(), 6'b11_0000);
        rst_n = 1'b1;
        bus.in_op = 4'b1110;
        #1;
        check_eq("jnc_post_rst", obs(), 6'b11_1000);

        // First edge after release captures the carry (still 1).
        @(posedge clk);
        #1;
        check_eq("jnc_after_edge", obs(), 6'b11_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
